// File: rtl/boreal_eeg_fusion_tdm.sv
// Time-multiplexed EEG DC-block and spatial fusion: one frame of N_CH samples in,
// one saturated weighted composite out, processed one channel per cycle on a shared MAC.
module boreal_eeg_fusion_tdm #(
   parameter int N_CH        = 8,
   parameter int DW          = 24,
   parameter int WW          = 16,
   parameter int ALPHA_SHIFT = 7,
   parameter int ACC_W       = 48
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_CH*DW-1:0]        in_data,
   input  logic [N_CH-1:0]           ch_mask,
   input  logic                      wr_en,
   output logic                      wr_ready,
   input  logic [$clog2(N_CH)-1:0]   wr_addr,
   input  logic [WW-1:0]             wr_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DW-1:0]             out_data,
   output logic                      out_sat,
   output logic                      busy
);

   // state | meaning
   // IDLE  | waiting for a frame; weight writes allowed
   // PROC  | one channel per cycle through the high-pass and MAC
   // OUT   | first cycle scales/clamps the sum, then holds the result until taken
   typedef enum logic [1:0] {IDLE, PROC, OUT} state_t;

   localparam int AW = $clog2(N_CH);
   localparam int PW = DW + 1 + WW;
   localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   state_t                   state, state_nxt;
   logic [N_CH*DW-1:0]       x_lat;
   logic [N_CH-1:0]          mask_lat;
   logic [AW-1:0]            ch_idx;
   logic signed [DW:0]       base   [N_CH];
   logic signed [WW-1:0]     weight [N_CH];
   logic signed [ACC_W-1:0]  acc;

   logic                     accept, wr_take, last_ch, out_take;
   logic signed [DW-1:0]     x_cur;
   logic signed [DW:0]       b_cur, hp, b_nxt;
   logic signed [WW-1:0]     w_cur;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  prod_ext, acc_sh;
   logic                     sat_hi, sat_lo;

   assign accept   = in_valid & in_ready;
   assign wr_take  = wr_en & wr_ready & ({1'b0, wr_addr} < (AW+1)'(N_CH));
   assign last_ch  = (ch_idx == AW'(N_CH-1));
   assign out_take = out_valid & out_ready;

   assign x_cur    = x_lat[ch_idx*DW +: DW];
   assign b_cur    = base[ch_idx];
   assign w_cur    = weight[ch_idx];
   assign hp       = $signed({x_cur[DW-1], x_cur}) - b_cur;
   assign b_nxt    = b_cur + (hp >>> ALPHA_SHIFT);
   assign prod     = hp * w_cur;
   assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
   assign acc_sh   = acc >>> 8;
   assign sat_hi   = (acc_sh > R_MAX);
   assign sat_lo   = (acc_sh < R_MIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = PROC;
         PROC:    if (last_ch)  state_nxt = OUT;
         OUT:     if (out_take) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      wr_ready = (state == IDLE);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_lat    <= '0;
         mask_lat <= '0;
         ch_idx   <= '0;
         acc      <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            x_lat    <= in_data;
            mask_lat <= ch_mask;
            ch_idx   <= '0;
            acc      <= '0;
         end
      end else if (state == PROC) begin
         if (mask_lat[ch_idx]) acc <= acc + prod_ext;
         if (!last_ch)         ch_idx <= ch_idx + 1'b1;
      end
   end

   // Baselines track every channel, masked or not, so re-enabling is glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) base[i] <= '0;
      end else if (state == PROC) begin
         base[ch_idx] <= b_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) weight[i] <= WW'(256);
      end else if (wr_take) begin
         weight[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (state == OUT) begin
         if (!out_valid) begin
            out_valid <= 1'b1;
            out_sat   <= sat_hi | sat_lo;
            if (sat_hi)      out_data <= {1'b0, {(DW-1){1'b1}}};
            else if (sat_lo) out_data <= {1'b1, {(DW-1){1'b0}}};
            else             out_data <= acc_sh[DW-1:0];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_boreal_eeg_fusion_tdm.sv
// Randomised and directed bench for boreal_eeg_fusion_tdm against a frame-level arithmetic model.
module tb_boreal_eeg_fusion_tdm;

   localparam int N_CH        = 8;
   localparam int DW          = 24;
   localparam int WW          = 16;
   localparam int ALPHA_SHIFT = 7;
   localparam int ACC_W       = 48;
   localparam int AW          = $clog2(N_CH);
   localparam longint MAXV    = (64'sd1 <<< (DW-1)) - 1;
   localparam longint MINV    = -(64'sd1 <<< (DW-1));

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid, in_ready;
   logic [N_CH*DW-1:0]   in_data;
   logic [N_CH-1:0]      ch_mask;
   logic                 wr_en, wr_ready;
   logic [AW-1:0]        wr_addr;
   logic [WW-1:0]        wr_data;
   logic                 out_valid, out_ready;
   logic [DW-1:0]        out_data;
   logic                 out_sat;
   logic                 busy;

   int n_cmp = 0;
   int n_err = 0;

   longint mb [N_CH];
   longint mw [N_CH];

   boreal_eeg_fusion_tdm #(
      .N_CH(N_CH), .DW(DW), .WW(WW), .ALPHA_SHIFT(ALPHA_SHIFT), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .ch_mask(ch_mask),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         mb[i] = 0;
         mw[i] = 256;
      end
   endtask

   // Frame result straight from the arithmetic rules: high-pass with old baseline,
   // weighted sum of enabled channels, divide by 256 (floor), clamp to DW bits.
   function automatic void model_frame(input logic [N_CH*DW-1:0] d, input logic [N_CH-1:0] m,
                                       output longint ed, output logic es);
      longint sum, x, hp, r;
      logic signed [DW-1:0] xs;
      sum = 0;
      for (int i = 0; i < N_CH; i++) begin
         xs = d[i*DW +: DW];
         x  = xs;
         hp = x - mb[i];
         mb[i] = mb[i] + (hp >>> ALPHA_SHIFT);
         if (m[i]) sum += hp * mw[i];
      end
      r = sum >>> 8;
      if (r > MAXV)      begin ed = MAXV; es = 1'b1; end
      else if (r < MINV) begin ed = MINV; es = 1'b1; end
      else               begin ed = r;    es = 1'b0; end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
      in_data = '0; ch_mask = '0; wr_addr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic write_w(input int wa, input logic signed [WW-1:0] wd);
      int k;
      logic [31:0] wa_v;
      wa_v = wa;
      wr_en = 1'b1; wr_addr = wa_v[AW-1:0]; wr_data = wd;
      k = 0;
      while (!wr_ready && k < 100) begin @(posedge clk); #1; k++; end
      chk("wr_ready_wait", wr_ready, 1);
      @(posedge clk); #1;
      wr_en = 1'b0;
      mw[wa] = wd;
   endtask

   task automatic accept_frame(input logic [N_CH*DW-1:0] d, input logic [N_CH-1:0] m,
                               input bit do_wr, input int wa, input logic signed [WW-1:0] wd,
                               output longint ed, output logic es);
      int k;
      logic [31:0] wa_v;
      wa_v = wa;
      in_data = d; ch_mask = m; in_valid = 1'b1;
      if (do_wr) begin wr_en = 1'b1; wr_addr = wa_v[AW-1:0]; wr_data = wd; end
      k = 0;
      while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
      chk("in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; wr_en = 1'b0;
      if (do_wr) mw[wa] = wd;
      model_frame(d, m, ed, es);
   endtask

   task automatic wait_result(input string tag, input longint ed, input logic es);
      int k;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!out_valid && k < 40);
      chk({tag, "_latency"}, k, N_CH + 1);
      chk({tag, "_data"}, $signed(out_data), ed);
      chk({tag, "_sat"}, out_sat, es);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   function automatic logic [N_CH*DW-1:0] fill(input int v);
      logic [N_CH*DW-1:0] d;
      logic [31:0] vv;
      vv = v;
      for (int i = 0; i < N_CH; i++) d[i*DW +: DW] = vv[DW-1:0];
      return d;
   endfunction

   initial begin
      longint ed;
      logic   es;
      logic [N_CH*DW-1:0] d, d2;
      logic [DW-1:0] hold_d;
      logic hold_s, seen;
      logic [31:0] r32;

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", busy, 0);

      accept_frame(fill(1000), '1, 0, 0, 0, ed, es);
      wait_result("dc1", ed, es);
      chk("dc1_const", $signed(out_data), 8000);
      drain("dc1");
      accept_frame(fill(1000), '1, 0, 0, 0, ed, es);
      wait_result("dc2", ed, es);
      chk("dc2_const", $signed(out_data), 7944);
      drain("dc2");

      accept_frame(fill(-1234), '1, 0, 0, 0, ed, es);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_data", out_data, 0);
      @(posedge clk); #1;
      chk("midrst_busy_next", busy, 0);
      chk("midrst_wr_ready_next", wr_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (N_CH + 6) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      chk("midrst_no_output", seen, 0);
      model_reset();

      d = fill(5000);
      r32 = -200;
      d[3*DW +: DW] = r32[DW-1:0];
      accept_frame(d, 8'h08, 1, 3, 16'sd512, ed, es);
      wait_result("maskwr", ed, es);
      chk("maskwr_const", $signed(out_data), -400);
      drain("maskwr");

      accept_frame(fill(777), '0, 0, 0, 0, ed, es);
      wait_result("allmask", ed, es);
      chk("allmask_zero", $signed(out_data), 0);
      drain("allmask");

      for (int i = 0; i < N_CH; i++) write_w(i, 16'sh7FFF);
      accept_frame(fill(32'h7FFFFF), '1, 0, 0, 0, ed, es);
      wait_result("sathi", ed, es);
      chk("sathi_const", out_data, 24'h7FFFFF);
      chk("sathi_flag", out_sat, 1);
      drain("sathi");

      do_reset();
      accept_frame(fill(32'h800000), '1, 0, 0, 0, ed, es);
      wait_result("satlo", ed, es);
      chk("satlo_const", out_data, 24'h800000);
      chk("satlo_flag", out_sat, 1);
      drain("satlo");

      for (int i = 0; i < N_CH; i++) begin
         r32 = $urandom_range(0, 200000) - 100000;
         d[i*DW +: DW] = r32[DW-1:0];
      end
      accept_frame(d, 8'hA5, 0, 0, 0, ed, es);
      wait_result("bp", ed, es);
      hold_d = out_data; hold_s = out_sat;
      for (int i = 0; i < N_CH; i++) begin
         r32 = $urandom_range(0, 200000) - 100000;
         d2[i*DW +: DW] = r32[DW-1:0];
      end
      in_data = d2; ch_mask = 8'h3C; in_valid = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFED4;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_data_stable", out_data, hold_d);
         chk("bp_sat_stable", out_sat, hold_s);
         chk("bp_valid_held", out_valid, 1);
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_wr_ready_low", wr_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_valid_drop", out_valid, 0);
      chk("bp_in_ready_back", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; wr_en = 1'b0;
      chk("bp_pending_taken", busy, 1);
      mw[2] = -300;
      model_frame(d2, 8'h3C, ed, es);
      wait_result("bp2", ed, es);
      drain("bp2");

      for (int f = 0; f < 24; f++) begin
         bit full, same_wr;
         int wa;
         logic signed [WW-1:0] wd;
         full = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < N_CH; i++) begin
            if (full) r32 = $urandom;
            else      r32 = $urandom_range(0, 1 << 20) - (1 << 19);
            d[i*DW +: DW] = r32[DW-1:0];
         end
         if ($urandom_range(0, 2) == 0) begin
            r32 = $urandom_range(0, 2048) - 1024;
            write_w($urandom_range(0, N_CH-1), r32[WW-1:0]);
         end
         same_wr = ($urandom_range(0, 2) == 0);
         wa = $urandom_range(0, N_CH-1);
         r32 = full ? $urandom : ($urandom_range(0, 2048) - 1024);
         wd = r32[WW-1:0];
         r32 = $urandom;
         accept_frame(d, r32[N_CH-1:0], same_wr, wa, wd, ed, es);
         wait_result("rand", ed, es);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         chk("rand_hold_data", $signed(out_data), ed);
         drain("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
